// File: rtl/rifl_tx_arbiter.sv
// Packet-granular round-robin arbiter sharing the RIFL TX user stream among N_SRC sources.
// Define RIFL_TX_ARB_STATS_EN to add per-source packet counters and a stall counter.
module rifl_tx_arbiter #(
  parameter int N_SRC    = 4,
  parameter int DWIDTH   = 256,
  parameter int ID_WIDTH = $clog2(N_SRC)
) (
  input  logic                      tx_frame_clk,
  input  logic                      tx_frame_rst,
  input  logic [N_SRC*DWIDTH-1:0]   s_axis_tdata,
  input  logic [N_SRC*DWIDTH/8-1:0] s_axis_tkeep,
  input  logic [N_SRC-1:0]          s_axis_tlast,
  input  logic [N_SRC-1:0]          s_axis_tvalid,
  output logic [N_SRC-1:0]          s_axis_tready,
  output logic [DWIDTH-1:0]         m_axis_tdata,
  output logic [DWIDTH/8-1:0]       m_axis_tkeep,
  output logic                      m_axis_tlast,
  output logic                      m_axis_tvalid,
  input  logic                      m_axis_tready,
  input  logic                      link_up,
  input  logic                      pause,
  output logic [ID_WIDTH-1:0]       grant_id,
  output logic                      busy
`ifdef RIFL_TX_ARB_STATS_EN
  ,
  output logic [N_SRC*32-1:0]       pkt_cnt,
  output logic [31:0]               stall_cnt
`endif
);

  typedef enum logic [0:0] {IDLE = 1'b0, XFER = 1'b1} state_t;

  state_t              state_q, state_d;
  logic [ID_WIDTH-1:0] rr_q, rr_d, grant_q, grant_d;
  logic                busy_q, busy_d;

  logic [DWIDTH-1:0]   src_tdata_s [N_SRC];
  logic [DWIDTH/8-1:0] src_tkeep_s [N_SRC];
  logic                xfer_s, eop_s, gate_s, arb_found_s;
  logic [ID_WIDTH-1:0] grant_inc_s, arb_ptr_s, arb_sel_s;
  logic [N_SRC-1:0]    arb_req_s, grant_oh_s;
  logic [ID_WIDTH:0]   idx_s;

  for (genvar k = 0; k < N_SRC; k++) begin : g_unpack
    assign src_tdata_s[k] = s_axis_tdata[k*DWIDTH +: DWIDTH];
    assign src_tkeep_s[k] = s_axis_tkeep[k*(DWIDTH/8) +: DWIDTH/8];
  end

  assign xfer_s      = (state_q == XFER);
  assign grant_oh_s  = {{(N_SRC-1){1'b0}}, 1'b1} << grant_q;
  assign grant_inc_s = (grant_q == ID_WIDTH'(N_SRC-1)) ? {ID_WIDTH{1'b0}} : grant_q + ID_WIDTH'(1);
  assign gate_s      = link_up & ~pause;
  assign eop_s       = xfer_s & m_axis_tvalid & m_axis_tready & m_axis_tlast;
  // While a packet ends, the next search skips its owner and starts just after it.
  assign arb_ptr_s   = xfer_s ? grant_inc_s : rr_q;
  assign arb_req_s   = xfer_s ? (s_axis_tvalid & ~grant_oh_s) : s_axis_tvalid;
  assign grant_id    = grant_q;
  assign busy        = busy_q;

  // Zero-latency forwarding of the granted source while a packet is locked.
  always_comb begin
    if (xfer_s) begin
      m_axis_tdata  = src_tdata_s[grant_q];
      m_axis_tkeep  = src_tkeep_s[grant_q];
      m_axis_tlast  = s_axis_tlast[grant_q];
      m_axis_tvalid = s_axis_tvalid[grant_q];
      s_axis_tready = grant_oh_s & {N_SRC{m_axis_tready}};
    end else begin
      m_axis_tdata  = {DWIDTH{1'b0}};
      m_axis_tkeep  = {(DWIDTH/8){1'b0}};
      m_axis_tlast  = 1'b0;
      m_axis_tvalid = 1'b0;
      s_axis_tready = {N_SRC{1'b0}};
    end
  end

  // Round-robin search: first requester at or after arb_ptr_s, modulo N_SRC.
  always_comb begin
    arb_found_s = 1'b0;
    arb_sel_s   = {ID_WIDTH{1'b0}};
    idx_s       = {(ID_WIDTH+1){1'b0}};
    for (int i = 0; i < N_SRC; i++) begin
      idx_s = {1'b0, arb_ptr_s} + (ID_WIDTH+1)'(i);
      if (idx_s >= (ID_WIDTH+1)'(N_SRC)) begin
        idx_s = idx_s - (ID_WIDTH+1)'(N_SRC);
      end else begin
        idx_s = idx_s;
      end
      if (!arb_found_s && arb_req_s[idx_s[ID_WIDTH-1:0]]) begin
        arb_found_s = 1'b1;
        arb_sel_s   = idx_s[ID_WIDTH-1:0];
      end else begin
        arb_sel_s   = arb_sel_s;
      end
    end
  end

  // Next-state logic for grant, pointer and packet lock.
  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    case (state_q)
      IDLE: begin
        if (gate_s && arb_found_s) begin
          grant_d = arb_sel_s;
          busy_d  = 1'b1;
          state_d = XFER;
        end else begin
          state_d = IDLE;
        end
      end
      XFER: begin
        if (eop_s) begin
          rr_d = grant_inc_s;
          if (gate_s && arb_found_s) begin
            grant_d = arb_sel_s;
          end else begin
            busy_d  = 1'b0;
            state_d = IDLE;
          end
        end else begin
          state_d = XFER;
        end
      end
      default: begin
        busy_d  = 1'b0;
        state_d = IDLE;
      end
    endcase
  end

  // Arbiter state registers.
  always_ff @(posedge tx_frame_clk) begin
    if (tx_frame_rst) begin
      state_q <= IDLE;
      rr_q    <= {ID_WIDTH{1'b0}};
      grant_q <= {ID_WIDTH{1'b0}};
      busy_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rr_q    <= rr_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
    end
  end

`ifdef RIFL_TX_ARB_STATS_EN
  logic [N_SRC*32-1:0] pkt_cnt_q, pkt_cnt_d;
  logic [31:0]         stall_cnt_q, stall_cnt_d;

  // Completed-packet and back-pressure counters; both wrap naturally.
  always_comb begin
    pkt_cnt_d = pkt_cnt_q;
    for (int k = 0; k < N_SRC; k++) begin
      if (eop_s && (grant_q == ID_WIDTH'(k))) begin
        pkt_cnt_d[k*32 +: 32] = pkt_cnt_q[k*32 +: 32] + 32'd1;
      end else begin
        pkt_cnt_d[k*32 +: 32] = pkt_cnt_q[k*32 +: 32];
      end
    end
    if (xfer_s && m_axis_tvalid && !m_axis_tready) begin
      stall_cnt_d = stall_cnt_q + 32'd1;
    end else begin
      stall_cnt_d = stall_cnt_q;
    end
  end

  // Statistics registers.
  always_ff @(posedge tx_frame_clk) begin
    if (tx_frame_rst) begin
      pkt_cnt_q   <= {(N_SRC*32){1'b0}};
      stall_cnt_q <= 32'd0;
    end else begin
      pkt_cnt_q   <= pkt_cnt_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign pkt_cnt   = pkt_cnt_q;
  assign stall_cnt = stall_cnt_q;
`endif

endmodule

// File: tb/tb_rifl_tx_arbiter.sv
// Self-checking bench for rifl_tx_arbiter: directed scenarios plus randomized traffic
// compared each cycle against a packet-level reference model.
module tb_rifl_tx_arbiter;
  localparam int N  = 4;
  localparam int DW = 32;
  localparam int KW = DW/8;
  localparam int IW = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic             rst;
  logic [N*DW-1:0]  s_tdata;
  logic [N*KW-1:0]  s_tkeep;
  logic [N-1:0]     s_tlast, s_tvalid, s_tready;
  logic [DW-1:0]    m_tdata;
  logic [KW-1:0]    m_tkeep;
  logic             m_tlast, m_tvalid, m_tready;
  logic             link_up, pause;
  logic [IW-1:0]    grant_id;
  logic             busy;
`ifdef RIFL_TX_ARB_STATS_EN
  logic [N*32-1:0]  pkt_cnt;
  logic [31:0]      stall_cnt;
`endif

  rifl_tx_arbiter #(.N_SRC(N), .DWIDTH(DW), .ID_WIDTH(IW)) dut (
    .tx_frame_clk (clk),
    .tx_frame_rst (rst),
    .s_axis_tdata (s_tdata),
    .s_axis_tkeep (s_tkeep),
    .s_axis_tlast (s_tlast),
    .s_axis_tvalid(s_tvalid),
    .s_axis_tready(s_tready),
    .m_axis_tdata (m_tdata),
    .m_axis_tkeep (m_tkeep),
    .m_axis_tlast (m_tlast),
    .m_axis_tvalid(m_tvalid),
    .m_axis_tready(m_tready),
    .link_up      (link_up),
    .pause        (pause),
    .grant_id     (grant_id),
`ifdef RIFL_TX_ARB_STATS_EN
    .busy         (busy),
    .pkt_cnt      (pkt_cnt),
    .stall_cnt    (stall_cnt)
`else
    .busy         (busy)
`endif
  );

  int checks = 0;
  int errors = 0;

  // Reference model: which source owns the stream, and where the next search starts.
  int m_busy, m_g, m_rr;
  int m_pkt[N];
  int m_stall;

  // Source packet generators.
  int            beat[N], len[N], left[N];
  logic [DW-1:0] dat[N];
  logic [KW-1:0] kp[N];
  logic [N-1:0]  cur_v;
  int            vprob, len_max, fix_len, rnd_ctl, cyc;
  int            beat_log[$];
  int            beat_cyc[$];

  task automatic chk(string tag, logic [63:0] obs, logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic int pick(int ptr, logic [N-1:0] req, int excl);
    for (int i = 0; i < N; i++) begin
      if (req[(ptr+i)%N] && ((ptr+i)%N != excl)) return (ptr+i)%N;
    end
    return -1;
  endfunction

  function automatic int new_len();
    return (fix_len > 0) ? fix_len : int'($urandom_range(len_max, 1));
  endfunction

  task automatic drive();
    for (int k = 0; k < N; k++) begin
      s_tdata[k*DW +: DW] = dat[k];
      s_tkeep[k*KW +: KW] = kp[k];
      s_tvalid[k]         = cur_v[k];
      s_tlast[k]          = (beat[k] == len[k]-1);
    end
  endtask

  task automatic model_reset();
    m_busy = 0; m_g = 0; m_rr = 0; m_stall = 0;
    for (int k = 0; k < N; k++) m_pkt[k] = 0;
  endtask

  task automatic gen_reset();
    for (int k = 0; k < N; k++) begin
      beat[k] = 0; len[k] = new_len(); cur_v[k] = 1'b0;
    end
  endtask

  task automatic gen_update(logic [N-1:0] hs);
    for (int k = 0; k < N; k++) begin
      if (hs[k]) begin
        cur_v[k] = 1'b0;
        if (beat[k] == len[k]-1) begin
          beat[k] = 0; left[k]--; len[k] = new_len();
        end else begin
          beat[k]++;
        end
      end
      if (!cur_v[k] && left[k] > 0 && int'($urandom_range(99, 0)) < vprob) begin
        cur_v[k] = 1'b1; dat[k] = $urandom; kp[k] = KW'($urandom);
      end
    end
  endtask

  // One clock cycle: check outputs against the model, step the model, drive new inputs.
  task automatic cycle();
    logic [DW-1:0] e_d;
    logic [KW-1:0] e_k;
    logic          e_v, e_l, gate;
    logic [N-1:0]  e_r, hs;
    int            ng, nb, nrr, p;
    #1;
    e_d = '0; e_k = '0; e_v = 1'b0; e_l = 1'b0; e_r = '0; hs = '0;
    if (m_busy != 0) begin
      e_v = cur_v[m_g]; e_d = dat[m_g]; e_k = kp[m_g];
      e_l = (beat[m_g] == len[m_g]-1);
      e_r[m_g] = m_tready;
    end
    chk("m_tvalid", m_tvalid, e_v);
    chk("m_tdata", m_tdata, e_d);
    chk("m_tkeep", m_tkeep, e_k);
    chk("m_tlast", m_tlast, e_l);
    chk("s_tready", s_tready, e_r);
    chk("busy", busy, m_busy[0]);
    chk("grant_id", grant_id, m_g[IW-1:0]);
`ifdef RIFL_TX_ARB_STATS_EN
    for (int k = 0; k < N; k++) chk("pkt_cnt", pkt_cnt[k*32 +: 32], 32'(m_pkt[k]));
    chk("stall_cnt", stall_cnt, 32'(m_stall));
`endif
    if (m_tvalid === 1'b1 && m_tready === 1'b1) begin
      beat_log.push_back(int'(grant_id));
      beat_cyc.push_back(cyc);
    end
    ng = m_g; nb = m_busy; nrr = m_rr;
    gate = link_up && !pause;
    if (m_busy == 0) begin
      p = pick(m_rr, cur_v, -1);
      if (gate && p >= 0) begin ng = p; nb = 1; end
    end else begin
      if (cur_v[m_g] && m_tready) hs[m_g] = 1'b1;
      if (!cur_v[m_g] ? 1'b0 : !m_tready) m_stall++;
      if (hs[m_g] && e_l) begin
        m_pkt[m_g]++;
        nrr = (m_g + 1) % N;
        p = pick(nrr, cur_v, m_g);
        if (gate && p >= 0) ng = p;
        else nb = 0;
      end
    end
    @(posedge clk);
    #1;
    cyc++;
    if (rst) begin
      model_reset();
      gen_reset();
    end else begin
      m_g = ng; m_busy = nb; m_rr = nrr;
      gen_update(hs);
    end
    if (rnd_ctl != 0) begin
      link_up  = ($urandom_range(99, 0) < 92);
      pause    = ($urandom_range(99, 0) < 8);
      m_tready = ($urandom_range(99, 0) < 75);
    end
    drive();
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    cycle();
    rst = 1'b0;
  endtask

  initial begin
    int n;
    rst = 1'b1; link_up = 1'b1; pause = 1'b0; m_tready = 1'b1;
    vprob = 100; len_max = 4; fix_len = 3; rnd_ctl = 0; cyc = 0;
    for (int k = 0; k < N; k++) begin left[k] = 0; dat[k] = '0; kp[k] = '0; end
    gen_reset();
    drive();
    @(posedge clk);
    #1;
    model_reset();
    @(negedge clk);
    do_reset();

    // Sources 0 and 2 each send one 3-beat packet: back-to-back, no bubble.
    left[0] = 1; left[2] = 1;
    gen_update('0);
    drive();
    beat_log.delete(); beat_cyc.delete();
    repeat (12) cycle();
    chk("t1_beats", beat_log.size(), 6);
    if (beat_log.size() == 6) begin
      for (int i = 0; i < 6; i++) chk("t1_order", beat_log[i], (i < 3) ? 0 : 2);
      chk("t1_no_bubble", beat_cyc[5] - beat_cyc[0], 5);
    end
    chk("t1_grant_last", grant_id, 2);

    // All sources stream 1-beat packets: one packet per cycle in round-robin order.
    fix_len = 1;
    do_reset();
    for (int k = 0; k < N; k++) left[k] = 8;
    beat_log.delete(); beat_cyc.delete();
    repeat (36) cycle();
    chk("t2_beats", beat_log.size(), 32);
    if (beat_log.size() == 32) begin
      for (int i = 0; i < 32; i++) chk("t2_order", beat_log[i], i % N);
      chk("t2_rate", beat_cyc[31] - beat_cyc[0], 31);
    end

    // Link down with every source requesting: nothing is granted.
    link_up = 1'b0; fix_len = 2;
    for (int k = 0; k < N; k++) left[k] = 100;
    beat_log.delete();
    repeat (20) begin
      cycle();
      chk("t3_busy", busy, 1'b0);
    end
    chk("t3_beats", beat_log.size(), 0);

    // Reset in beat 2 of a 5-beat packet abandons it.
    link_up = 1'b1; fix_len = 5;
    for (int k = 0; k < N; k++) left[k] = (k == 1) ? 1 : 0;
    do_reset();
    beat_log.delete();
    n = 0;
    while (beat_log.size() < 1 && n < 20) begin cycle(); n++; end
    chk("t4_first_beat", beat_log.size(), 1);
    rst = 1'b1;
    cycle();
    rst = 1'b0;
    #1;
    chk("t4_grant", grant_id, 0);
    chk("t4_busy", busy, 1'b0);
    chk("t4_ready", s_tready, 4'b0000);
    chk("t4_valid", m_tvalid, 1'b0);
`ifdef RIFL_TX_ARB_STATS_EN
    chk("t4_pkt_cnt", pkt_cnt, '0);
`endif
    cycle();

    // Randomized traffic, link, pause and back-pressure.
    fix_len = 0; len_max = 4; vprob = 70; rnd_ctl = 1;
    for (int k = 0; k < N; k++) left[k] = 1000000;
    repeat (3000) cycle();

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
